encode_sequencer: RTL

ENCODE_SEQUENCER -- requirements
Module: encode_sequencer

---
 rtl/encode_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/encode_sequencer.sv
// rtl/encode_sequencer.sv - sequences fetch/bind/rotate/accumulate/threshold for one HV encode
module encode_sequencer #(
  parameter int NUM_FEATURES = 16,
  parameter int LEVEL_BITS   = 4,
  parameter int FEAT_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEVEL_BITS-1:0] feature_level,
  output logic [FEAT_W-1:0]     feat_idx,
  output logic [LEVEL_BITS-1:0] level_addr,
  output logic                  bind_en,
  output logic                  start_binding,
  output logic                  bind_src_sel,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  thresh_en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [FEAT_W-1:0] LAST_IDX = FEAT_W'(NUM_FEATURES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_ROTATE,
    S_ACCUM,
    S_THRESH,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [FEAT_W-1:0] rot_cnt;

  // State register; reset parks the sequencer in IDLE immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection plus Moore decode of every strobe from the current state.
  always_comb begin
    state_d       = state_q;
    bind_en       = 1'b0;
    start_binding = 1'b0;
    bind_src_sel  = 1'b0;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;
    thresh_en     = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bind_en       = 1'b1;
        start_binding = 1'b1;
        state_d       = (feat_idx != '0) ? S_ROTATE : S_ACCUM;
      end
      S_ROTATE: begin
        bind_en       = 1'b1;
        start_binding = 1'b1;
        bind_src_sel  = 1'b1;
        // Only reachable with feat_idx >= 1, so the subtraction never wraps.
        if (rot_cnt == feat_idx - FEAT_W'(1)) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_en  = 1'b1;
        state_d = (feat_idx == LAST_IDX) ? S_THRESH : S_FETCH;
      end
      S_THRESH: begin
        thresh_en = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort cancels any encode in flight; IDLE is already where it would go.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Feature index, item-memory address and rotation counter updates.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      feat_idx   <= '0;
      level_addr <= '0;
      rot_cnt    <= '0;
    end else if (!abort) begin
      case (state_q)
        S_CLEAR: begin
          feat_idx <= '0;
        end
        S_FETCH: begin
          level_addr <= feature_level;
          rot_cnt    <= '0;
        end
        S_ROTATE: begin
          rot_cnt <= rot_cnt + FEAT_W'(1);
        end
        S_ACCUM: begin
          if (feat_idx != LAST_IDX) feat_idx <= feat_idx + FEAT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
